// File: rtl/pwconv_engine_if.sv
// Stream bundle for the pointwise conv engine: weight, activation and result
// channels, each a valid/ready handshake.
interface pwconv_engine_if #(
    parameter int MAC_IN_NUM  = 10,
    parameter int MAC_OUT_NUM = 16,
    parameter int DATA_WIDTH  = 8
);
    logic                              w_valid;
    logic                              w_ready;
    logic [MAC_IN_NUM*DATA_WIDTH-1:0]  w_data;
    logic                              in_valid;
    logic                              in_ready;
    logic [MAC_IN_NUM*DATA_WIDTH-1:0]  in_data;
    logic                              out_valid;
    logic                              out_ready;
    logic [MAC_OUT_NUM*DATA_WIDTH-1:0] out_data;

    modport master (
        output w_valid, w_data, in_valid, in_data, out_ready,
        input  w_ready, in_ready, out_valid, out_data
    );

    modport slave (
        input  w_valid, w_data, in_valid, in_data, out_ready,
        output w_ready, in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pwconv_engine.sv
// Pointwise (1x1) convolution engine: weight bank preload, grouped MAC
// accumulation, shift + saturate requantisation. PWCONV_RELU_EN adds ReLU.
module pwconv_engine #(
    parameter int MAC_IN_NUM  = 10,
    parameter int MAC_OUT_NUM = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int ACC_WIDTH   = 24,
    parameter int CNT_WIDTH   = 10,
    parameter int MAX_GROUPS  = 8,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_start,
    input  logic                   cfg_load_w,
    input  logic [CNT_WIDTH-1:0]   cfg_groups,
    input  logic [CNT_WIDTH-1:0]   cfg_pixels,
    input  logic [SHIFT_WIDTH-1:0] cfg_shift,
    pwconv_engine_if.slave         bus,
    output logic                   busy,
    output logic                   done
);
    localparam int IN_W  = MAC_IN_NUM * DATA_WIDTH;
    localparam int DEPTH = MAX_GROUPS * MAC_OUT_NUM;
    localparam int ROW_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int O_W   = MAC_OUT_NUM > 1 ? $clog2(MAC_OUT_NUM) : 1;
    localparam logic signed [ACC_WIDTH-1:0] Q_MAX =
        ACC_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] Q_MIN =
        ACC_WIDTH'(-(2 ** (DATA_WIDTH - 1)));

    typedef enum logic [1:0] {IDLE, LOAD_W, RUN, DRAIN} state_t;

    state_t                        state, state_nx;
    logic [CNT_WIDTH-1:0]          groups_q, pixels_q, groups_clamp;
    logic [SHIFT_WIDTH-1:0]        shift_q;
    logic [CNT_WIDTH-1:0]          grp_cnt, pix_cnt;
    logic [ROW_W-1:0]              grp_base;
    logic [O_W-1:0]                o_cnt;
    logic [IN_W-1:0]               bank [DEPTH];
    logic signed [ACC_WIDTH-1:0]   dot_c   [MAC_OUT_NUM];
    logic signed [ACC_WIDTH-1:0]   s1_prod [MAC_OUT_NUM];
    logic signed [ACC_WIDTH-1:0]   acc     [MAC_OUT_NUM];
    logic signed [ACC_WIDTH-1:0]   acc_nx  [MAC_OUT_NUM];
    logic                          s1_valid, s1_first, s1_last;
    logic                          stall, w_fire, in_fire, out_fire;
    logic                          grp_last, pix_last, o_last;

    function automatic logic signed [ACC_WIDTH-1:0] dot(
        input logic [IN_W-1:0] w,
        input logic [IN_W-1:0] a
    );
        logic signed [ACC_WIDTH-1:0]    sum;
        logic signed [DATA_WIDTH-1:0]   wi, ai;
        logic signed [2*DATA_WIDTH-1:0] p;
        sum = '0;
        for (int i = 0; i < MAC_IN_NUM; i++) begin
            wi  = w[i*DATA_WIDTH +: DATA_WIDTH];
            ai  = a[i*DATA_WIDTH +: DATA_WIDTH];
            p   = (2*DATA_WIDTH)'(wi) * (2*DATA_WIDTH)'(ai);
            sum = sum + ACC_WIDTH'(p);
        end
        return sum;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] requant(
        input logic signed [ACC_WIDTH-1:0] v,
        input logic [SHIFT_WIDTH-1:0]      sh
    );
        logic signed [ACC_WIDTH-1:0] s;
        logic [DATA_WIDTH-1:0]       r;
        s = v >>> sh;
`ifdef PWCONV_RELU_EN
        if (s[ACC_WIDTH-1]) s = '0;
`endif
        if (s > Q_MAX)      r = Q_MAX[DATA_WIDTH-1:0];
        else if (s < Q_MIN) r = Q_MIN[DATA_WIDTH-1:0];
        else                r = s[DATA_WIDTH-1:0];
        return r;
    endfunction

    assign stall        = bus.out_valid & ~bus.out_ready;
    assign bus.w_ready  = (state == LOAD_W);
    assign bus.in_ready = (state == RUN) & ~stall;
    assign w_fire       = bus.w_valid & bus.w_ready;
    assign in_fire      = bus.in_valid & bus.in_ready;
    assign out_fire     = bus.out_valid & bus.out_ready;
    assign grp_last     = (grp_cnt == groups_q - CNT_WIDTH'(1));
    assign pix_last     = (pix_cnt == pixels_q - CNT_WIDTH'(1));
    assign o_last       = (o_cnt == O_W'(MAC_OUT_NUM - 1));

    // Clamp the requested group count into 1..MAX_GROUPS
    always_comb begin
        groups_clamp = cfg_groups;
        if (cfg_groups == '0)
            groups_clamp = CNT_WIDTH'(1);
        else if (cfg_groups > CNT_WIDTH'(MAX_GROUPS))
            groups_clamp = CNT_WIDTH'(MAX_GROUPS);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state decode plus busy/done status
    always_comb begin
        state_nx = state;
        busy     = (state != IDLE);
        done     = 1'b0;
        unique case (state)
            IDLE:   if (cfg_start) state_nx = cfg_load_w ? LOAD_W : RUN;
            LOAD_W: if (w_fire && o_last && grp_last) state_nx = RUN;
            RUN:    if (in_fire && grp_last && pix_last) state_nx = DRAIN;
            DRAIN:  if (out_fire && !s1_valid) begin
                        state_nx = IDLE;
                        done     = 1'b1;
                    end
            default: state_nx = IDLE;
        endcase
    end

    // Config latch and group/pixel/row counters (shared by load and run)
    always_ff @(posedge clk) begin
        if (rst) begin
            groups_q <= CNT_WIDTH'(1);
            pixels_q <= CNT_WIDTH'(1);
            shift_q  <= '0;
            grp_cnt  <= '0;
            grp_base <= '0;
            pix_cnt  <= '0;
            o_cnt    <= '0;
        end else if (state == IDLE && cfg_start) begin
            groups_q <= groups_clamp;
            pixels_q <= cfg_pixels;
            shift_q  <= cfg_shift;
            grp_cnt  <= '0;
            grp_base <= '0;
            pix_cnt  <= '0;
            o_cnt    <= '0;
        end else if (w_fire || in_fire) begin
            if (w_fire && !o_last) begin
                o_cnt <= o_cnt + O_W'(1);
            end else begin
                o_cnt <= '0;
                if (grp_last) begin
                    grp_cnt  <= '0;
                    grp_base <= '0;
                    if (in_fire) pix_cnt <= pix_cnt + CNT_WIDTH'(1);
                end else begin
                    grp_cnt  <= grp_cnt + CNT_WIDTH'(1);
                    grp_base <= grp_base + ROW_W'(MAC_OUT_NUM);
                end
            end
        end
    end

    // Weight bank write; contents survive reset
    always_ff @(posedge clk) begin
        if (w_fire) bank[grp_base + ROW_W'(o_cnt)] <= bus.w_data;
    end

    // Dot products of the current beat against this group's rows
    always_comb begin
        for (int o = 0; o < MAC_OUT_NUM; o++)
            dot_c[o] = dot(bank[grp_base + ROW_W'(o)], bus.in_data);
    end

    // S1: register products and group position of the accepted beat
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_prod  <= '{default: '0};
        end else if (!stall) begin
            s1_valid <= in_fire;
            if (in_fire) begin
                s1_prod  <= dot_c;
                s1_first <= (grp_cnt == '0);
                s1_last  <= grp_last;
            end
        end
    end

    // Running sum, restarted on group 0
    always_comb begin
        for (int o = 0; o < MAC_OUT_NUM; o++)
            acc_nx[o] = (s1_first ? '0 : acc[o]) + s1_prod[o];
    end

    // S2: accumulate, or requantise into the output register on last group
    always_ff @(posedge clk) begin
        if (rst) begin
            acc           <= '{default: '0};
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
        end else if (!stall) begin
            bus.out_valid <= s1_valid & s1_last;
            if (s1_valid) begin
                for (int o = 0; o < MAC_OUT_NUM; o++) begin
                    if (s1_last)
                        bus.out_data[o*DATA_WIDTH +: DATA_WIDTH] <=
                            requant(acc_nx[o], shift_q);
                    else
                        acc[o] <= acc_nx[o];
                end
            end
        end
    end
endmodule
